// File: rtl/gray_fifo_ptr_ctrl.sv
// Gray-coded FIFO pointer controller for a single-clock shared buffer RAM.
// Produces RAM addresses, occupancy flags, Gray pointers and error pulses.
module gray_fifo_ptr_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 2**ADDR_W-2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_accept,
    output logic              rd_accept,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0] r_wr_bin;
    logic [ADDR_W:0] r_rd_bin;
    logic [ADDR_W:0] r_wr_gray;
    logic [ADDR_W:0] r_rd_gray;
    logic            r_ovf;
    logic            r_udf;

    logic [ADDR_W:0] w_count;
    logic [ADDR_W:0] w_wr_next;
    logic [ADDR_W:0] w_rd_next;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;

    assign w_count = r_wr_bin - r_rd_bin;
    assign w_empty = (r_wr_bin == r_rd_bin);
    assign w_full  = (r_wr_bin[ADDR_W] != r_rd_bin[ADDR_W]) &&
                     (r_wr_bin[ADDR_W-1:0] == r_rd_bin[ADDR_W-1:0]);

    // Accept decisions only look at flags from the start of the cycle.
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    assign w_wr_next = r_wr_bin + ONE;
    assign w_rd_next = r_rd_bin + ONE;

    // Write pointer: binary and Gray copies advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
        end else if (w_wr_acc) begin
            r_wr_bin  <= w_wr_next;
            r_wr_gray <= w_wr_next ^ (w_wr_next >> 1);
        end
    end

    // Read pointer: binary and Gray copies advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
        end else if (w_rd_acc) begin
            r_rd_bin  <= w_rd_next;
            r_rd_gray <= w_rd_next ^ (w_rd_next >> 1);
        end
    end

    // One-cycle error pulses for requests made against full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= wr_en && w_full;
            r_udf <= rd_en && w_empty;
        end
    end

    assign wr_addr      = r_wr_bin[ADDR_W-1:0];
    assign rd_addr      = r_rd_bin[ADDR_W-1:0];
    assign wr_accept    = w_wr_acc;
    assign rd_accept    = w_rd_acc;
    assign wr_ptr_gray  = r_wr_gray;
    assign rd_ptr_gray  = r_rd_gray;
    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= AF_TH);
    assign almost_empty = (w_count <= AE_TH);
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Bench for gray_fifo_ptr_ctrl: reference pointer model feeding a
// scoreboard queue of expected post-edge state.
module tb_gray_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] wr_addr;
    logic [3:0] rd_addr;
    logic       wr_accept;
    logic       rd_accept;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    gray_fifo_ptr_ctrl #(.ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .wr_accept(wr_accept),
        .rd_accept(rd_accept),
        .wr_ptr_gray(wr_ptr_gray),
        .rd_ptr_gray(rd_ptr_gray),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] cnt;
        logic       f;
        logic       e;
        logic       af;
        logic       ae;
        logic [4:0] wg;
        logic [4:0] rg;
        logic       ov;
        logic       un;
        logic       wmov;
        logic       rmov;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [4:0] m_wr = '0;
    logic [4:0] m_rd = '0;
    logic [4:0] prev_wg = '0;
    logic [4:0] prev_rg = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        logic [4:0] g;
        for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
        g[4] = b[4];
        return g;
    endfunction

    task automatic step(input logic r, input logic w, input logic d);
        logic [4:0] cnt;
        logic       mf, me, wacc, racc;
        exp_t       e;
        exp_t       got;
        rst   = r;
        wr_en = w;
        rd_en = d;
        #1;
        cnt  = m_wr - m_rd;
        mf   = (cnt == 5'd16);
        me   = (cnt == 5'd0);
        wacc = w && !mf;
        racc = d && !me;
        if (!r) begin
            chk("wr_accept", wr_accept, wacc);
            chk("rd_accept", rd_accept, racc);
            chk("wr_addr", wr_addr, m_wr[3:0]);
            chk("rd_addr", rd_addr, m_rd[3:0]);
        end
        e = '0;
        if (r) begin
            m_wr = '0;
            m_rd = '0;
        end else begin
            if (wacc) m_wr = m_wr + 5'd1;
            if (racc) m_rd = m_rd + 5'd1;
            e.ov   = w && mf;
            e.un   = d && me;
            e.wmov = wacc;
            e.rmov = racc;
        end
        e.cnt = m_wr - m_rd;
        e.f   = (e.cnt == 5'd16);
        e.e   = (e.cnt == 5'd0);
        e.af  = (e.cnt >= 5'd14);
        e.ae  = (e.cnt <= 5'd2);
        e.wg  = to_gray(m_wr);
        e.rg  = to_gray(m_rd);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("count", count, got.cnt);
        chk("full", full, got.f);
        chk("empty", empty, got.e);
        chk("almost_full", almost_full, got.af);
        chk("almost_empty", almost_empty, got.ae);
        chk("wr_ptr_gray", wr_ptr_gray, got.wg);
        chk("rd_ptr_gray", rd_ptr_gray, got.rg);
        chk("overflow", overflow, got.ov);
        chk("underflow", underflow, got.un);
        if (got.wmov)
            chk("wg_hamming", $countones(prev_wg ^ wr_ptr_gray), 1);
        if (got.rmov)
            chk("rg_hamming", $countones(prev_rg ^ rd_ptr_gray), 1);
        prev_wg = wr_ptr_gray;
        prev_rg = rd_ptr_gray;
    endtask

    initial begin
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        chk("idle_wg", wr_ptr_gray, 5'b00000);
        chk("idle_rg", rd_ptr_gray, 5'b00000);

        for (int i = 0; i < 16; i++) step(0, 1, 0);
        chk("fill_wg", wr_ptr_gray, 5'b11000);
        chk("fill_full", full, 1'b1);
        chk("fill_cnt", count, 5'd16);

        step(0, 1, 0);
        chk("ovf_pulse", overflow, 1'b1);
        step(0, 0, 0);
        chk("ovf_clear", overflow, 1'b0);
        step(0, 1, 1);
        chk("full_rw_cnt", count, 5'd15);
        chk("full_rw_ovf", overflow, 1'b1);

        for (int i = 0; i < 15; i++) step(0, 0, 1);
        chk("drained", empty, 1'b1);

        step(0, 1, 0);
        for (int i = 0; i < 70; i++) step(0, 1, 1);
        chk("stream_cnt", count, 5'd1);

        step(0, 0, 1);
        step(0, 0, 1);
        chk("udf_rd", underflow, 1'b1);
        step(0, 1, 1);
        chk("udf_rw", underflow, 1'b1);
        chk("udf_rw_cnt", count, 5'd1);
        step(0, 0, 1);

        for (int i = 0; i < 9; i++) step(0, 1, 0);
        chk("pre_rst_cnt", count, 5'd9);
        step(1, 1, 0);
        chk("rst_cnt", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_wg", wr_ptr_gray, 5'b00000);
        step(0, 1, 0);
        step(0, 0, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
